// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004 program-counter sequencer: op codes,
// fault codes, FSM state encoding and the PC/SP widths.
package tb4004_pkg;

  localparam int PC_W = 12;
  localparam int SP_W = 3;

  localparam logic [2:0] OP_INC1 = 3'd0;
  localparam logic [2:0] OP_INC2 = 3'd1;
  localparam logic [2:0] OP_JUN  = 3'd2;
  localparam logic [2:0] OP_JMS  = 3'd3;
  localparam logic [2:0] OP_BBL  = 3'd4;
  localparam logic [2:0] OP_JCN  = 3'd5;
  localparam logic [2:0] OP_JIN  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_POP_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Command handshake between the instruction decoder (master) and the
// PC sequencer (slave).
interface pc_ctrl_if #(
  parameter int PC_W = tb4004_pkg::PC_W
);
  logic            cmdValid;
  logic            cmdReady;
  logic [2:0]      cmdOp;
  logic [PC_W-1:0] cmdAddr;

  modport master (output cmdValid, output cmdOp, output cmdAddr, input cmdReady);
  modport slave  (input cmdValid, input cmdOp, input cmdAddr, output cmdReady);
endinterface

// File: rtl/pc_addr_calc.sv
// Combinational next-PC candidate for every op code, plus the pc+2 return
// address. All arithmetic wraps modulo 2**PC_W.
module pc_addr_calc #(
  parameter int PC_W = tb4004_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      cmdOp,
  input  logic [PC_W-1:0] cmdAddr,
  output logic [PC_W-1:0] nextPc,
  output logic [PC_W-1:0] pcPlus2
);
  import tb4004_pkg::*;

  logic [PC_W-1:0] pcPlus1;

  assign pcPlus1 = pc + PC_W'(1);
  assign pcPlus2 = pc + PC_W'(2);

  // BBL falls to pc+1, which is exactly the underflow fallback.
  always_comb begin
    // NOTE: default first so no path leaves nextPc unassigned (no latch).
    nextPc = pcPlus1;
    case (cmdOp)
      OP_INC2:        nextPc = pcPlus2;
      OP_JUN, OP_JMS: nextPc = cmdAddr;
      OP_JCN:         nextPc = {pcPlus2[PC_W-1:8], cmdAddr[7:0]};
      OP_JIN:         nextPc = {pcPlus1[PC_W-1:8], cmdAddr[7:0]};
      default:        nextPc = pcPlus1;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// 4004 program-counter sequencer driving the call/return stack.
// Optional: PC_CTRL_FAULT_HALT_EN makes any stack fault park the FSM in HALT.
module pc_ctrl #(
  parameter int PC_W = tb4004_pkg::PC_W,
  parameter int SP_W = tb4004_pkg::SP_W
) (
  input  logic            clk,
  input  logic            rst,
  pc_ctrl_if.slave        cmd,
  output logic [PC_W-1:0] pc,
  output logic            stkPush,
  output logic            stkPop,
  output logic [PC_W-1:0] stkPcIn,
  input  logic [PC_W-1:0] stkPcOut,
  input  logic [SP_W-1:0] stkSp,
  output logic            fault,
  output logic [1:0]      faultCode
);
  import tb4004_pkg::*;

  state_t          state;
  logic            ready;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] pcPlus2;
  logic            accept, isJms, isBbl, spFull, spEmpty, ovf, unf;

  pc_addr_calc #(.PC_W(PC_W)) u_calc (
    .pc      (pc),
    .cmdOp   (cmd.cmdOp),
    .cmdAddr (cmd.cmdAddr),
    .nextPc  (nextPc),
    .pcPlus2 (pcPlus2)
  );

  assign cmd.cmdReady = ready;
  assign accept  = cmd.cmdValid && ready;
  assign isJms   = (cmd.cmdOp == OP_JMS);
  assign isBbl   = (cmd.cmdOp == OP_BBL);
  assign spFull  = (stkSp == {SP_W{1'b1}});
  assign spEmpty = (stkSp == '0);
  assign ovf     = isJms && spFull;
  assign unf     = isBbl && spEmpty;

  // Depth pre-check keeps strobes off a full/empty stack; reset masks both.
  assign stkPush = !rst && accept && isJms && !spFull;
  assign stkPop  = !rst && accept && isBbl && !spEmpty;
  assign stkPcIn = pcPlus2;

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      pc        <= '0;
      fault     <= 1'b0;
      faultCode <= FLT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (ovf || unf) begin
              fault <= 1'b1;
              if (!fault) faultCode <= ovf ? FLT_OVF : FLT_UNF;
`ifdef PC_CTRL_FAULT_HALT_EN
              state <= ST_HALT;
              ready <= 1'b0;
`else
              pc    <= nextPc;
`endif
            end else if (isBbl) begin
              state <= ST_POP_WAIT;
              ready <= 1'b0;
            end else begin
              pc <= nextPc;
            end
          end
        end
        ST_POP_WAIT: begin
          // Stack output is registered: popped address is valid now.
          pc    <= stkPcOut;
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        ST_HALT: ready <= 1'b0;
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl; expectations follow
// PC_CTRL_FAULT_HALT_EN when it is defined.
module tb_pc_ctrl;
  import tb4004_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pc, stkPcIn, stkPcOut;
  logic        stkPush, stkPop, fault;
  logic [1:0]  faultCode;
  logic [2:0]  stkSp;

  pc_ctrl_if cif ();

  pc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .pc        (pc),
    .stkPush   (stkPush),
    .stkPop    (stkPop),
    .stkPcIn   (stkPcIn),
    .stkPcOut  (stkPcOut),
    .stkSp     (stkSp),
    .fault     (fault),
    .faultCode (faultCode)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  logic        capPush, capPop, capReady, capFault;
  logic [11:0] capPcIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for one cycle; capture pre-edge strobes.
  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [2:0] sp);
    @(negedge clk);
    cif.cmdValid = 1'b1;
    cif.cmdOp    = op;
    cif.cmdAddr  = addr;
    stkSp        = sp;
    #1;
    capPush  = stkPush;
    capPop   = stkPop;
    capReady = cif.cmdReady;
    capFault = fault;
    capPcIn  = stkPcIn;
    @(posedge clk);
    #1;
    cif.cmdValid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    cif.cmdValid = 1'b1;
    cif.cmdOp    = OP_JMS;
    cif.cmdAddr  = 12'h345;
    stkSp        = 3'd0;
    stkPcOut     = 12'h000;

    // Reset state, with a live command trying to strobe the stack.
    #12;
    check("rst_pc", pc, 12'h000);
    check("rst_ready", cif.cmdReady, 1'b1);
    check("rst_push_masked", stkPush, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_fcode", faultCode, 2'b00);
    check("rst_pcin", stkPcIn, 12'h002);
    cif.cmdOp = OP_BBL;
    stkSp     = 3'd1;
    #1;
    check("rst_pop_masked", stkPop, 1'b0);
    cif.cmdValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Increment sequence and wrap.
    issue(OP_INC1, 12'h000, 3'd0); check("inc1_a", pc, 12'h001);
    issue(OP_INC1, 12'h000, 3'd0); check("inc1_b", pc, 12'h002);
    issue(OP_INC1, 12'h000, 3'd0); check("inc1_c", pc, 12'h003);
    issue(OP_INC2, 12'h000, 3'd0); check("inc2", pc, 12'h005);
    issue(OP_JUN,  12'hFFF, 3'd0); check("jun_fff", pc, 12'hFFF);
    check("pcin_wrap", stkPcIn, 12'h001);
    issue(OP_INC1, 12'h000, 3'd0); check("inc1_wrap", pc, 12'h000);

    // Call then return.
    issue(OP_JUN, 12'h120, 3'd0);
    issue(OP_JMS, 12'h345, 3'd0);
    check("jms_push", capPush, 1'b1);
    check("jms_nopop", capPop, 1'b0);
    check("jms_pcin", capPcIn, 12'h122);
    check("jms_pc", pc, 12'h345);
    issue(OP_BBL, 12'h000, 3'd1);
    check("bbl_pop", capPop, 1'b1);
    check("bbl_nopush", capPush, 1'b0);
    check("bbl_wait_ready", cif.cmdReady, 1'b0);
    check("bbl_wait_pc", pc, 12'h345);
    stkPcOut = 12'h122;
    // A command offered during POP_WAIT must be ignored.
    @(negedge clk);
    cif.cmdValid = 1'b1;
    cif.cmdOp    = OP_BBL;
    #1;
    check("wait_no_pop", stkPop, 1'b0);
    @(posedge clk);
    #1;
    cif.cmdValid = 1'b0;
    check("bbl_pc", pc, 12'h122);
    check("bbl_ready", cif.cmdReady, 1'b1);

    // Push at depth 6 is still legal.
    issue(OP_JMS, 12'h0C0, 3'd6);
    check("jms_sp6_push", capPush, 1'b1);
    check("jms_sp6_pc", pc, 12'h0C0);

    // Page-relative jumps.
    issue(OP_JUN, 12'h2FE, 3'd0);
    issue(OP_JCN, 12'h044, 3'd0); check("jcn_edge", pc, 12'h344);
    issue(OP_JUN, 12'h2FC, 3'd0);
    issue(OP_JCN, 12'h044, 3'd0); check("jcn_inpage", pc, 12'h244);
    issue(OP_JUN, 12'h2FF, 3'd0);
    issue(OP_JIN, 12'h0AB, 3'd0); check("jin_edge", pc, 12'h3AB);
    issue(OP_RSVD, 12'h000, 3'd0); check("rsvd_inc", pc, 12'h3AC);

    // Reset during POP_WAIT discards the pending load.
    issue(OP_BBL, 12'h000, 3'd3);
    stkPcOut = 12'h777;
    rst = 1'b1;
    #1;
    check("rstpw_pc", pc, 12'h000);
    check("rstpw_ready", cif.cmdReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstpw_ignore", pc, 12'h000);

    // Overflow.
    issue(OP_JUN, 12'h100, 3'd0);
    issue(OP_JMS, 12'h500, 3'd7);
    check("ovf_nopush", capPush, 1'b0);
    check("ovf_fault_pre", capFault, 1'b0);
    check("ovf_fault", fault, 1'b1);
    check("ovf_fcode", faultCode, 2'b01);
`ifdef PC_CTRL_FAULT_HALT_EN
    check("ovf_pc_frozen", pc, 12'h100);
    check("ovf_halt_ready", cif.cmdReady, 1'b0);
    issue(OP_INC1, 12'h000, 3'd0);
    check("halt_ignore", pc, 12'h100);
    check("halt_ready", cif.cmdReady, 1'b0);
`else
    check("ovf_pc_jun", pc, 12'h500);
    check("ovf_ready", cif.cmdReady, 1'b1);
`endif
    pulse_reset();
    check("clr_fault", fault, 1'b0);
    check("clr_ready", cif.cmdReady, 1'b1);

    // Underflow.
    issue(OP_JUN, 12'h010, 3'd0);
    issue(OP_BBL, 12'h000, 3'd0);
    check("unf_nopop", capPop, 1'b0);
    check("unf_fault", fault, 1'b1);
    check("unf_fcode", faultCode, 2'b10);
`ifdef PC_CTRL_FAULT_HALT_EN
    check("unf_pc_frozen", pc, 12'h010);
    check("unf_halt_ready", cif.cmdReady, 1'b0);
`else
    check("unf_pc_inc", pc, 12'h011);
    check("unf_ready", cif.cmdReady, 1'b1);
    // First fault wins: a later overflow keeps the underflow code.
    issue(OP_JMS, 12'h500, 3'd7);
    check("first_wins", faultCode, 2'b10);
    check("first_wins_pc", pc, 12'h500);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
